// File: rtl/rfid_manchester_decoder.sv
// ISO 14443-A PICC->PCD Manchester decoder.
// Consumes signed load-modulation samples, integrates energy per half-bit
// window, decodes SOF / data+odd parity / EOF, and emits decoded bytes on an
// 8-bit AXI-Stream master. Every byte is held pending for one byte time so that
// the frame's final byte can be tagged with tlast when EOF arrives.
module rfid_manchester_decoder #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int SAMPLES_PER_HALF_BIT   = 16,
    parameter int SAMPLE_THRESH          = 1000,
    parameter int HALF_THRESH            = 8000
) (
    input  logic                              s00_axis_aclk,
    input  logic                              s00_axis_aresetn,
    input  logic                              s00_axis_tvalid,
    output logic                              s00_axis_tready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                              s00_axis_tlast,
    input  logic                              m00_axis_tready,
    output logic                              m00_axis_tvalid,
    output logic [7:0]                        m00_axis_tdata,
    output logic                              m00_axis_tuser,
    output logic                              m00_axis_tlast,
    output logic                              frame_err_out,
    output logic                              overflow_out
);
    localparam int W     = C_S00_AXIS_TDATA_WIDTH;
    localparam int CNT_W = $clog2(SAMPLES_PER_HALF_BIT);
    localparam int ACC_W = W + CNT_W;

    localparam logic [CNT_W-1:0] LAST_SMP = CNT_W'(SAMPLES_PER_HALF_BIT - 1);
    localparam logic [W-1:0]     SMP_T    = W'(SAMPLE_THRESH);
    localparam logic [ACC_W-1:0] HALF_T   = ACC_W'(HALF_THRESH);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SOF_H1  = 3'd1;
    localparam logic [2:0] SOF_H2  = 3'd2;
    localparam logic [2:0] DATA_H1 = 3'd3;
    localparam logic [2:0] DATA_H2 = 3'd4;

    // Frame-level tlast on the input side carries no meaning for decoding.
    logic unused_tlast;
    assign unused_tlast = s00_axis_tlast;

    logic             tready_q;
    logic [2:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             h1_q, h1_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             pend_vld_q, pend_vld_d;
    logic [7:0]       pend_data_q, pend_data_d;
    logic             pend_user_q, pend_user_d;
    logic             out_vld_q, out_vld_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_user_q, out_user_d;
    logic             out_last_q, out_last_d;
    logic             ferr_q, ferr_d;
    logic             ovf_q, ovf_d;

    logic             beat;
    logic [W-1:0]     abs_x;
    logic [ACC_W-1:0] sum;
    logic             loaded;

    assign beat = s00_axis_tvalid & tready_q;

    // Magnitude of the sample; the most negative code saturates to max positive.
    always_comb begin
        abs_x = s00_axis_tdata;
        if (s00_axis_tdata == {1'b1, {(W-1){1'b0}}})
            abs_x = {1'b0, {(W-1){1'b1}}};
        else if (s00_axis_tdata[W-1])
            abs_x = -s00_axis_tdata;
    end

    assign sum    = acc_q + ACC_W'(abs_x);
    assign loaded = sum > HALF_T;

    // Window integration, Manchester FSM, pending byte and output register.
    always_comb begin
        logic       win_done;
        logic       bit_val;
        logic       push;
        logic [7:0] push_data;
        logic       push_user;
        logic       push_last;

        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        h1_d        = h1_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        pend_vld_d  = pend_vld_q;
        pend_data_d = pend_data_q;
        pend_user_d = pend_user_q;
        ferr_d      = 1'b0;
        ovf_d       = ovf_q;
        win_done    = 1'b0;
        bit_val     = 1'b0;
        push        = 1'b0;
        push_data   = pend_data_q;
        push_user   = pend_user_q;
        push_last   = 1'b0;

        if (beat) begin
            if (state_q == IDLE) begin
                // The triggering sample is the first sample of the SOF window.
                if (abs_x > SMP_T) begin
                    acc_d   = ACC_W'(abs_x);
                    cnt_d   = CNT_W'(1);
                    state_d = SOF_H1;
                end
            end else if (cnt_q == LAST_SMP) begin
                acc_d    = '0;
                cnt_d    = '0;
                win_done = 1'b1;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (win_done) begin
            case (state_q)
                SOF_H1: state_d = loaded ? SOF_H2 : IDLE;
                SOF_H2: begin
                    if (!loaded) begin
                        state_d   = DATA_H1;
                        bit_cnt_d = 4'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DATA_H1: begin
                    h1_d    = loaded;
                    state_d = DATA_H2;
                end
                DATA_H2: begin
                    if (h1_q != loaded) begin
                        // (1,0) is a one, (0,1) is a zero.
                        bit_val = h1_q;
                        state_d = DATA_H1;
                        if (bit_cnt_q == 4'd8) begin
                            // Odd parity expected: an even total count is an error.
                            if (pend_vld_q) push = 1'b1;
                            pend_vld_d  = 1'b1;
                            pend_data_d = shift_q;
                            pend_user_d = ~(^shift_q ^ bit_val);
                            bit_cnt_d   = 4'd0;
                        end else begin
                            shift_d[bit_cnt_q[2:0]] = bit_val;
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end else if (!h1_q) begin
                        // EOF: flush the pending byte as the last of the frame.
                        push       = pend_vld_q;
                        push_last  = 1'b1;
                        pend_vld_d = 1'b0;
                        ferr_d     = (bit_cnt_q != 4'd0);
                        state_d    = IDLE;
                    end else begin
                        ferr_d     = 1'b1;
                        pend_vld_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        out_vld_d  = out_vld_q & ~m00_axis_tready;
        out_data_d = out_data_q;
        out_user_d = out_user_q;
        out_last_d = out_last_q;
        if (push) begin
            if (!out_vld_q || m00_axis_tready) begin
                out_vld_d  = 1'b1;
                out_data_d = push_data;
                out_user_d = push_user;
                out_last_d = push_last;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // State registers; reset drops everything including in-flight bytes.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            tready_q    <= 1'b0;
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            h1_q        <= 1'b0;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'd0;
            pend_vld_q  <= 1'b0;
            pend_data_q <= 8'd0;
            pend_user_q <= 1'b0;
            out_vld_q   <= 1'b0;
            out_data_q  <= 8'd0;
            out_user_q  <= 1'b0;
            out_last_q  <= 1'b0;
            ferr_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            tready_q    <= 1'b1;
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            h1_q        <= h1_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            pend_vld_q  <= pend_vld_d;
            pend_data_q <= pend_data_d;
            pend_user_q <= pend_user_d;
            out_vld_q   <= out_vld_d;
            out_data_q  <= out_data_d;
            out_user_q  <= out_user_d;
            out_last_q  <= out_last_d;
            ferr_q      <= ferr_d;
            ovf_q       <= ovf_d;
        end
    end

    assign s00_axis_tready = tready_q;
    assign m00_axis_tvalid = out_vld_q;
    assign m00_axis_tdata  = out_data_q;
    assign m00_axis_tuser  = out_user_q;
    assign m00_axis_tlast  = out_last_q;
    assign frame_err_out   = ferr_q;
    assign overflow_out    = ovf_q;
endmodule

// File: tb/tb_rfid_manchester_decoder.sv
// Directed bench for rfid_manchester_decoder: whole frames built from
// loaded/unloaded half-bits, decoded beats collected by a sink monitor.
module tb_rfid_manchester_decoder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic        m_tready;
    logic        m_tvalid;
    logic [7:0]  m_tdata;
    logic        m_tuser;
    logic        m_tlast;
    logic        ferr;
    logic        ovf;

    int checks = 0;
    int failures = 0;
    int err_cnt = 0;
    logic gap_en = 1'b0;
    logic [9:0] beats[$];

    always #5 clk = ~clk;

    rfid_manchester_decoder dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .s00_axis_tvalid  (s_tvalid),
        .s00_axis_tready  (s_tready),
        .s00_axis_tdata   (s_tdata),
        .s00_axis_tlast   (s_tlast),
        .m00_axis_tready  (m_tready),
        .m00_axis_tvalid  (m_tvalid),
        .m00_axis_tdata   (m_tdata),
        .m00_axis_tuser   (m_tuser),
        .m00_axis_tlast   (m_tlast),
        .frame_err_out    (ferr),
        .overflow_out     (ovf)
    );

    // Sink monitor: a beat is taken on the posedge following this negedge.
    always @(negedge clk) begin
        if (rst_n && m_tvalid && m_tready) beats.push_back({m_tdata, m_tuser, m_tlast});
        if (rst_n && ferr) err_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic put_sample(input logic [31:0] v);
        if (gap_en) idle($urandom_range(0, 2));
        s_tvalid = 1'b1;
        s_tdata  = v;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        s_tdata  = 32'd0;
    endtask

    task automatic half(input logic ld);
        for (int i = 0; i < 16; i++)
            put_sample(ld ? ((i % 2 == 0) ? 32'd2000 : 32'hFFFF_F830) : 32'd0);
    endtask

    task automatic send_bit(input logic b);
        if (b) begin half(1'b1); half(1'b0); end
        else   begin half(1'b0); half(1'b1); end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic p);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
    endtask

    task automatic sof(); half(1'b1); half(1'b0); endtask
    task automatic eof(); half(1'b0); half(1'b0); endtask

    task automatic clear_mon();
        beats.delete();
        err_cnt = 0;
    endtask

    task automatic test_reset();
        logic [13:0] got;
        rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = 32'd0; s_tlast = 1'b0; m_tready = 1'b1;
        idle(3);
        got = {s_tready, m_tvalid, m_tdata, m_tuser, m_tlast, ferr, ovf};
        checks++;
        if (got !== 14'd0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=0", got);
        end
        rst_n = 1'b1;
        idle(1);
        checks++;
        if (s_tready !== 1'b1) begin
            failures++; $display("FAIL tready_after_reset got=%b exp=1", s_tready);
        end
    endtask

    task automatic test_single();
        logic [9:0] got;
        clear_mon();
        sof(); send_byte(8'hA5, 1'b1); eof();
        checks++;
        if (m_tvalid !== 1'b1) begin
            failures++; $display("FAIL a5_latency tvalid got=%b exp=1", m_tvalid);
        end
        idle(5);
        checks++;
        if (beats.size() != 1) begin
            failures++; $display("FAIL a5_count got=%0d exp=1", beats.size());
        end
        got = (beats.size() > 0) ? beats[0] : 10'h3FF;
        checks++;
        if (got !== {8'hA5, 1'b0, 1'b1}) begin
            failures++; $display("FAIL a5_beat got=%h exp=%h", got, {8'hA5, 1'b0, 1'b1});
        end
        checks++;
        if ({err_cnt != 0, ovf} !== 2'b00) begin
            failures++; $display("FAIL a5_flags err_cnt=%0d ovf=%b exp=0/0", err_cnt, ovf);
        end
    endtask

    task automatic test_gaps();
        logic [9:0] b0, b1;
        clear_mon();
        gap_en = 1'b1;
        sof(); send_byte(8'h93, 1'b1); send_byte(8'h20, 1'b0); eof();
        gap_en = 1'b0;
        idle(5);
        checks++;
        if (beats.size() != 2) begin
            failures++; $display("FAIL gaps_count got=%0d exp=2", beats.size());
        end
        b0 = (beats.size() > 0) ? beats[0] : 10'h3FF;
        b1 = (beats.size() > 1) ? beats[1] : 10'h3FF;
        checks++;
        if (b0 !== {8'h93, 1'b0, 1'b0}) begin
            failures++; $display("FAIL gaps_beat0 got=%h exp=%h", b0, {8'h93, 1'b0, 1'b0});
        end
        checks++;
        if (b1 !== {8'h20, 1'b0, 1'b1}) begin
            failures++; $display("FAIL gaps_beat1 got=%h exp=%h", b1, {8'h20, 1'b0, 1'b1});
        end
    endtask

    task automatic test_parity_err();
        logic [9:0] got;
        clear_mon();
        sof(); send_byte(8'h93, 1'b0); eof();
        idle(5);
        got = (beats.size() == 1) ? beats[0] : 10'h3FF;
        checks++;
        if (got !== {8'h93, 1'b1, 1'b1}) begin
            failures++; $display("FAIL parity_beat got=%h exp=%h size=%0d", got, {8'h93, 1'b1, 1'b1}, beats.size());
        end
    endtask

    task automatic test_violation();
        logic [9:0] got;
        clear_mon();
        sof(); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        half(1'b1); half(1'b1);
        checks++;
        if (ferr !== 1'b1) begin
            failures++; $display("FAIL viol_pulse got=%b exp=1", ferr);
        end
        idle(1);
        checks++;
        if (ferr !== 1'b0) begin
            failures++; $display("FAIL viol_pulse_end got=%b exp=0", ferr);
        end
        idle(5);
        checks++;
        if (err_cnt != 1 || beats.size() != 0) begin
            failures++; $display("FAIL viol_counts err_cnt=%0d beats=%0d exp=1/0", err_cnt, beats.size());
        end
        clear_mon();
        sof(); send_byte(8'h5A, 1'b1); eof();
        idle(5);
        got = (beats.size() == 1) ? beats[0] : 10'h3FF;
        checks++;
        if (got !== {8'h5A, 1'b0, 1'b1}) begin
            failures++; $display("FAIL viol_recover got=%h exp=%h size=%0d", got, {8'h5A, 1'b0, 1'b1}, beats.size());
        end
    endtask

    task automatic test_overflow();
        logic [9:0] got;
        clear_mon();
        m_tready = 1'b0;
        sof(); send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1); eof();
        idle(2);
        checks++;
        if ({ovf, m_tvalid, m_tdata, m_tlast} !== {1'b1, 1'b1, 8'h11, 1'b0}) begin
            failures++; $display("FAIL ovf_hold ovf=%b tvalid=%b tdata=%h tlast=%b exp=1/1/11/0", ovf, m_tvalid, m_tdata, m_tlast);
        end
        m_tready = 1'b1;
        idle(5);
        checks++;
        if (beats.size() != 1) begin
            failures++; $display("FAIL ovf_count got=%0d exp=1", beats.size());
        end
        got = (beats.size() > 0) ? beats[0] : 10'h3FF;
        checks++;
        if (got !== {8'h11, 1'b0, 1'b0}) begin
            failures++; $display("FAIL ovf_beat got=%h exp=%h", got, {8'h11, 1'b0, 1'b0});
        end
        checks++;
        if ({m_tvalid, ovf} !== 2'b01) begin
            failures++; $display("FAIL ovf_after tvalid=%b ovf=%b exp=0/1", m_tvalid, ovf);
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0]  got;
        logic [13:0] outs;
        clear_mon();
        sof(); send_byte(8'h93, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        rst_n = 1'b0;
        #1;
        outs = {s_tready, m_tvalid, m_tdata, m_tuser, m_tlast, ferr, ovf};
        checks++;
        if (outs !== 14'd0) begin
            failures++; $display("FAIL midreset_outputs got=%h exp=0", outs);
        end
        idle(3);
        rst_n = 1'b1;
        idle(5);
        checks++;
        if (beats.size() != 0) begin
            failures++; $display("FAIL midreset_beats got=%0d exp=0", beats.size());
        end
        sof(); send_byte(8'hA5, 1'b1); eof();
        idle(5);
        got = (beats.size() == 1) ? beats[0] : 10'h3FF;
        checks++;
        if (got !== {8'hA5, 1'b0, 1'b1}) begin
            failures++; $display("FAIL midreset_recover got=%h exp=%h size=%0d", got, {8'hA5, 1'b0, 1'b1}, beats.size());
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_gaps();
        test_parity_err();
        test_violation();
        test_overflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rfid_manchester_decoder.md
# rfid_manchester_decoder

Downstream consumer of the PICC→PCD AXI-Stream sample stream. Accepts 32-bit signed load-modulated samples, measures energy per half-bit window, and decodes ISO 14443-A Manchester framing: SOF, 8 data bits LSB-first, odd parity, EOF. Decoded bytes leave on an 8-bit AXI-Stream master with per-byte parity status and frame-end `tlast`.

## Interface
- `C_S00_AXIS_TDATA_WIDTH`, 32, input sample width (signed).
- `SAMPLES_PER_HALF_BIT`, 16, accepted samples per Manchester half-bit (≥2).
- `SAMPLE_THRESH`, 1000, per-sample abs level that starts SOF alignment.
- `HALF_THRESH`, 8000, window energy above which a half-bit is "loaded".
- `s00_axis_aclk`  in  1  sole clock; the m00 side also uses it.
- `s00_axis_aresetn`  in  1  asynchronous, active-low reset.
- `s00_axis_tvalid`  in  1  sample valid.
- `s00_axis_tready`  out  1  sample ready.
- `s00_axis_tdata`  in  32  signed sample.
- `s00_axis_tlast`  in  1  ignored.
- `m00_axis_tready`  in  1  byte sink ready.
- `m00_axis_tvalid`  out  1  byte valid.
- `m00_axis_tdata`  out  8  decoded byte.
- `m00_axis_tuser`  out  1  parity error for this byte.
- `m00_axis_tlast`  out  1  last byte of frame.
- `frame_err_out`  out  1  one-cycle pulse on Manchester violation or partial byte at EOF.
- `overflow_out`  out  1  sticky until reset; a byte was dropped.

## Operation
- Reset values: all outputs 0, state IDLE, accumulators and pending buffer cleared. `s00_axis_tready` is 1 from the first cycle after reset release; samples are never back-pressured.
- Only accepted beats (`tvalid & tready`) advance counters. Idle cycles are transparent.
- |x| = abs(tdata); −2^31 saturates to 2^31−1. Accumulator width is 32+clog2(SAMPLES_PER_HALF_BIT), unsigned. The half-bit decision `loaded = (acc + |x|) > HALF_THRESH` is made on the beat carrying the window's last sample. The accumulator clears on that same beat.
- States:
  - IDLE: wait for an accepted beat with |x| > SAMPLE_THRESH. That beat is sample 0 of the SOF_H1 window. Move to SOF_H1.
  - SOF_H1: window loaded → SOF_H2; otherwise → IDLE.
  - SOF_H2: window unloaded → DATA_H1, bit_cnt=0; otherwise → IDLE. No error pulse in either case.
  - DATA_H1: record the half value → DATA_H2.
  - DATA_H2: pair (H1,H2) decodes as follows:
    - (1,0) = bit 1; (0,1) = bit 0. Shift bit into bit position bit_cnt (0–7) or the parity slot (bit_cnt=8). bit_cnt wraps 8→0 on parity.
    - (0,0) = EOF.
    - (1,1) = violation: pulse `frame_err_out`, discard pending byte, → IDLE.
- Byte complete (parity slot filled): tuser = (popcount(data)+parity) is even. The previously pending byte, if any, is pushed with tlast=0. The new byte becomes pending. Return to DATA_H1.
- EOF with bit_cnt=0:
  - If a byte is pending, push it with tlast=1.
  - Then go to IDLE.
- EOF with bit_cnt≠0:
  - Push the pending byte (if any) with tlast=1.
  - Drop the partial byte and pulse `frame_err_out`.
  - Go to IDLE.
- Push into the single output register:
  - If the register is empty, or `m00_axis_tready` is high that cycle, load it.
  - Otherwise drop the new byte and set `overflow_out`. The register contents are untouched.
- Reset mid-frame clears everything immediately, including any pending or registered byte.

## Timing
- Half-bit decision is registered: the state changes on the clock edge that accepts the window's last sample.
- Byte N is not emitted when it completes; it is held pending, so every byte is delayed by one byte time. `m00_axis_tvalid` rises the cycle after either:
  - the last sample of byte N+1's parity bit is accepted, or
  - the last sample of the EOF bit is accepted.
- `m00_axis_tvalid` holds with stable tdata/tuser/tlast until `m00_axis_tready`. It deasserts the cycle after the handshake unless a push occurs in that same cycle.
- A push and a handshake in the same cycle are legal: the new byte is loaded, with no bubble and no overflow.
- `frame_err_out` is high for exactly one cycle, on the cycle after the deciding sample.

## Test plan
Stimulus encoding: loaded half = 16 samples alternating +2000/−2000; unloaded half = 16 zeros; frame = SOF(1,0) + bytes + EOF(0,0); `m00_axis_tready`=1 unless stated.
- Frame with 0xA5, parity 1 → one beat: tdata=0xA5, tuser=0, tlast=1. `frame_err_out` and `overflow_out` stay 0.
- Frame 0x93/p1, 0x20/p0, random input tvalid gaps → beats 0x93 (tlast=0) then 0x20 (tlast=1), both tuser=0.
- Frame 0x93 sent with parity 0 → one beat: tdata=0x93, tuser=1, tlast=1.
- Frame 0x11, 0x22, 0x33 (correct parity), `m00_axis_tready`=0 until after EOF → `overflow_out`=1. After tready rises, exactly one beat: 0x11, tlast=0.
- Byte 0xA5 with half-pair (1,1) at bit 3 → `frame_err_out` one-cycle pulse and no beat. A following valid 0x5A frame decodes correctly.
- Frame 0x93, 0x20 with `s00_axis_aresetn` low during the second byte → all outputs 0 immediately and no beat. A fresh 0xA5 frame after release decodes correctly.
